// File: rtl/eda_fifo_pkg.sv
// rtl/eda_fifo_pkg.sv - shared FIFO mode constants, default sizes and elaboration-check helpers
package eda_fifo_pkg;

    localparam int CFG_DATA_WIDTH = 8;
    localparam int CFG_FIFO_DEPTH = 16;

    localparam bit FIFO_MODE_FWFT = 1'b1;
    localparam bit FIFO_MODE_REG  = 1'b0;

    function automatic bit fifo_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifo_thresh_ok(input int ae_thresh, input int af_thresh);
        return ae_thresh < af_thresh;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, synchronous write and combinational read
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Contents are deliberately left unreset so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with count, programmable thresholds, flush and sticky errors
module sync_fifo_ctrl
    import eda_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int MEM_DEPTH  = CFG_FIFO_DEPTH,
    parameter int AF_THRESH  = MEM_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = FIFO_MODE_FWFT,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    generate
        if (!fifo_is_pow2(MEM_DEPTH)) begin : g_bad_depth
            $error("sync_fifo_ctrl: MEM_DEPTH must be a power of 2");
        end
        if (!fifo_thresh_ok(AE_THRESH, AF_THRESH)) begin : g_bad_thresh
            $error("sync_fifo_ctrl: AE_THRESH must be below AF_THRESH");
        end
    endgenerate

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // A flush swallows any same-cycle request, so neither counts as accepted nor rejected.
    assign rd_acc = !clr && rd_en && !empty;
    assign wr_acc = !clr && wr_en && (!full || rd_acc);

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rd_data  = mem_rd_data;
            assign rd_valid = !empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: the popped word appears for exactly one cycle, then holds without valid.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_rd_data;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - randomized self-checking bench for sync_fifo_ctrl in both read modes
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] f_rd_data, r_rd_data;
    logic          f_rd_valid, r_rd_valid;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [3:0]    f_count, r_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_rvalid;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_reg (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_rvalid = 0;
        m_rdata = '0;
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        check({ctx, " f.count"}, 32'(f_count), 32'(n));
        check({ctx, " r.count"}, 32'(r_count), 32'(n));
        check({ctx, " f.empty"}, 32'(f_empty), 32'(n == 0));
        check({ctx, " r.empty"}, 32'(r_empty), 32'(n == 0));
        check({ctx, " f.full"}, 32'(f_full), 32'(n == DEPTH));
        check({ctx, " r.full"}, 32'(r_full), 32'(n == DEPTH));
        check({ctx, " f.af"}, 32'(f_af), 32'(n >= AF));
        check({ctx, " f.ae"}, 32'(f_ae), 32'(n <= AE));
        check({ctx, " r.af"}, 32'(r_af), 32'(n >= AF));
        check({ctx, " r.ae"}, 32'(r_ae), 32'(n <= AE));
        check({ctx, " f.ovf"}, 32'(f_ovf), 32'(m_ovf));
        check({ctx, " f.unf"}, 32'(f_unf), 32'(m_unf));
        check({ctx, " r.ovf"}, 32'(r_ovf), 32'(m_ovf));
        check({ctx, " r.unf"}, 32'(r_unf), 32'(m_unf));
        check({ctx, " f.rd_valid"}, 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) check({ctx, " f.rd_data"}, 32'(f_rd_data), 32'(q[0]));
        check({ctx, " r.rd_valid"}, 32'(r_rd_valid), 32'(m_rvalid));
        check({ctx, " r.rd_data"}, 32'(r_rd_data), 32'(m_rdata));
    endtask

    // One clock: inputs driven at negedge, reference updated from the FIFO rules, outputs checked 1 time unit later.
    task automatic step(input string ctx, input bit c, input bit w, input logic [DW-1:0] d, input bit r);
        bit racc, wacc;
        @(negedge clk);
        clr = c; wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_rvalid = 0;
        end else begin
            racc = r && (q.size() > 0);
            wacc = w && ((q.size() < DEPTH) || racc);
            m_rvalid = racc;
            if (racc) m_rdata = q.pop_front();
            if (wacc) q.push_back(d);
            if (w && !wacc) m_ovf = 1;
            if (r && !racc) m_unf = 1;
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        logic [DW-1:0] held;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 9; i++) step("fill", 0, 1, DW'(i), 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 0, '0, 1);
        held = f_rd_data;
        step("underflow", 0, 0, '0, 1);
        check("unf f.rd_data held", 32'(f_rd_data), 32'(held));
        check("unf r.rd_data held", 32'(r_rd_data), 32'(8'h08));

        step("clr", 1, 0, '0, 0);
        for (int i = 1; i <= 8; i++) step("refill", 0, 1, DW'(i), 0);
        step("full push+pop", 0, 1, 8'hAA, 1);
        check("full push+pop r.rd_data", 32'(r_rd_data), 32'h01);

        step("clr2", 1, 1, 8'h55, 1);
        for (int i = 0; i < 3; i++) step("prime", 0, 1, DW'($urandom), 0);
        for (int i = 0; i < 20; i++) step("wrap", 0, 1, DW'($urandom), 1);

        step("clr3", 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step("load5", 0, 1, DW'($urandom), 0);
        step("clr count5", 1, 0, '0, 1);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55),
                 DW'($urandom), ($urandom_range(0, 99) < 50));
        end

        for (int i = 0; i < 4; i++) step("burst", 0, 1, DW'($urandom), 0);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        reset_n = 1'b1;
        step("post reset", 0, 1, 8'h77, 0);
        step("post reset rd", 0, 0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
